feistel_engine_param: RTL and testbench

- Parametrised iterative Feistel block-cipher core; successor to the fixed 128-bit, 16-round, encrypt-only datapath.
- Adds generic block width, round count and key rotation, an encrypt/decrypt mode, and valid/ready handshakes on input and output.
- Sits between the host data register and the ciphertext output register.
- One round per clock, with a single shared round-function instance.

---
 rtl/feistel_pkg.sv | 29 ++
 rtl/feistel_engine_param_round_f.sv | 18 +
 rtl/feistel_engine_param.sv | 131 +++++++++++++
 tb/tb_feistel_engine_param.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feistel_pkg.sv
// Shared definitions for the iterative Feistel core: FSM encoding, round-function
// rotation constant and width-generic rotate helpers.
package feistel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int F_ROT = 3;
   // Widest operand the rotate helpers handle; callers cast in and out.
   localparam int MAX_W = 1024;

   function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int w, input int s);
      logic [MAX_W-1:0] m;
      logic [MAX_W-1:0] xm;
      int               sh;
      m  = {MAX_W{1'b1}} >> (MAX_W - w);
      xm = x & m;
      sh = s % w;
      return ((xm << sh) | (xm >> (w - sh))) & m;
   endfunction

   function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x, input int w, input int s);
      return rotl(x, w, w - (s % w));
   endfunction

endpackage

// File: rtl/feistel_engine_param_round_f.sv
// Combinational Feistel round function F(R,K) = rotl(R^K, 3) + K, modulo 2^H.
// No latency and no flow control.
module feistel_round_f
   import feistel_pkg::*;
#(
   parameter int H = 64
) (
   input  logic [H-1:0] r_i,
   input  logic [H-1:0] k_i,
   output logic [H-1:0] f_o
);

   logic [H-1:0] mix;

   assign mix = H'(rotl(MAX_W'(r_i ^ k_i), H, F_ROT));
   assign f_o = mix + k_i;

endmodule

// File: rtl/feistel_engine_param.sv
// Iterative Feistel cipher, one round per clock; result visible ROUNDS edges after accept.
// Accepts only in IDLE; DONE holds data_o until out_ready_i, with no input queued meanwhile.
module feistel_engine_param
   import feistel_pkg::*;
#(
   parameter int BLOCK_W = 128,
   parameter int ROUNDS  = 16,
   parameter int ROT     = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [BLOCK_W-1:0] data_i,
   input  logic [BLOCK_W-1:0] key_i,
   input  logic               mode_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [BLOCK_W-1:0] data_o,
   output logic               busy_o,
   output logic [7:0]         round_cnt_o
);

   localparam int H       = BLOCK_W / 2;
   localparam int DEC_ROT = (ROUNDS * ROT) % BLOCK_W;

   state_e             state_q, state_d;
   logic [H-1:0]       l_q, l_d, r_q, r_d;
   logic [BLOCK_W-1:0] kr_q, kr_d;
   logic [BLOCK_W-1:0] out_q, out_d;
   logic               mode_q, mode_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               in_rdy_q, in_rdy_d;
   logic               out_vld_q, out_vld_d;
   logic               busy_q, busy_d;
   logic [H-1:0]       f;

   feistel_round_f #(.H(H)) u_round_f (
      .r_i (r_q),
      .k_i (kr_q[H-1:0]),
      .f_o (f)
   );

   always_comb begin
      state_d   = state_q;
      l_d       = l_q;
      r_d       = r_q;
      kr_d      = kr_q;
      out_d     = out_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      in_rdy_d  = in_rdy_q;
      out_vld_d = out_vld_q;
      busy_d    = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               l_d      = data_i[BLOCK_W-1:H];
               r_d      = data_i[H-1:0];
               mode_d   = mode_i;
               cnt_d    = 8'd0;
               // Decrypt starts from the last round key and walks backwards.
               kr_d     = mode_i ? BLOCK_W'(rotl(MAX_W'(key_i), BLOCK_W, DEC_ROT))
                                 : BLOCK_W'(rotl(MAX_W'(key_i), BLOCK_W, ROT));
               in_rdy_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            l_d   = r_q;
            r_d   = l_q ^ f;
            cnt_d = cnt_q + 8'd1;
            kr_d  = mode_q ? BLOCK_W'(rotr(MAX_W'(kr_q), BLOCK_W, ROT))
                           : BLOCK_W'(rotl(MAX_W'(kr_q), BLOCK_W, ROT));
            if (cnt_q == 8'(ROUNDS - 1)) begin
               out_d     = {l_q ^ f, r_q};
               out_vld_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               out_vld_d = 1'b0;
               in_rdy_d  = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            out_vld_d = 1'b0;
            in_rdy_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         l_q       <= '0;
         r_q       <= '0;
         kr_q      <= '0;
         out_q     <= '0;
         mode_q    <= 1'b0;
         cnt_q     <= 8'd0;
         in_rdy_q  <= 1'b1;
         out_vld_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         l_q       <= l_d;
         r_q       <= r_d;
         kr_q      <= kr_d;
         out_q     <= out_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         in_rdy_q  <= in_rdy_d;
         out_vld_q <= out_vld_d;
         busy_q    <= busy_d;
      end
   end

   assign in_ready_o  = in_rdy_q;
   assign out_valid_o = out_vld_q;
   assign data_o      = out_q;
   assign busy_o      = busy_q;
   assign round_cnt_o = cnt_q;

endmodule

// File: tb/tb_feistel_engine_param.sv
// Directed bench for feistel_engine_param: a 16-bit single-round instance with
// hand-computed vectors and a default 128/16/1 instance checked against a reference.
module tb_feistel_engine_param;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   // Instance A: BLOCK_W=16, ROUNDS=1, ROT=1
   logic        a_in_vld, a_in_rdy, a_mode, a_out_vld, a_out_rdy, a_busy;
   logic [15:0] a_dat, a_key, a_dat_o;
   logic [7:0]  a_cnt;

   // Instance B: defaults 128/16/1
   logic         b_in_vld, b_in_rdy, b_mode, b_out_vld, b_out_rdy, b_busy;
   logic [127:0] b_dat, b_key, b_dat_o;
   logic [7:0]   b_cnt;

   feistel_engine_param #(.BLOCK_W(16), .ROUNDS(1), .ROT(1)) dut_a (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .in_valid_i (a_in_vld), .in_ready_o (a_in_rdy),
      .data_i (a_dat), .key_i (a_key), .mode_i (a_mode),
      .out_valid_o (a_out_vld), .out_ready_i (a_out_rdy),
      .data_o (a_dat_o), .busy_o (a_busy), .round_cnt_o (a_cnt)
   );

   feistel_engine_param dut_b (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .in_valid_i (b_in_vld), .in_ready_o (b_in_rdy),
      .data_i (b_dat), .key_i (b_key), .mode_i (b_mode),
      .out_valid_o (b_out_vld), .out_ready_i (b_out_rdy),
      .data_o (b_dat_o), .busy_o (b_busy), .round_cnt_o (b_cnt)
   );

   function automatic logic [127:0] rotl128(input logic [127:0] x, input int s);
      logic [255:0] t;
      t = {x, x} << (s % 128);
      return t[255:128];
   endfunction

   // Reference encrypt for 128/16/1, round keys taken directly as rotl(K, i)
   function automatic logic [127:0] model_enc(input logic [127:0] p, input logic [127:0] k);
      logic [63:0]  l, r, kk, f, t;
      logic [127:0] ks;
      l = p[127:64];
      r = p[63:0];
      for (int i = 1; i <= 16; i++) begin
         ks = rotl128(k, i);
         kk = ks[63:0];
         t  = r ^ kk;
         f  = {t[60:0], t[63:61]} + kk;
         t  = l ^ f;
         l  = r;
         r  = t;
      end
      return {r, l};
   endfunction

   // lat counts edges with the accept edge as 1
   task automatic run_a(input logic [15:0] p, input logic [15:0] k, input logic m,
                        output logic [15:0] res, output int lat, output logic [7:0] cnt);
      @(negedge clk_i);
      a_in_vld = 1'b1; a_dat = p; a_key = k; a_mode = m;
      @(negedge clk_i);
      lat = 1;
      a_in_vld = 1'b0; a_dat = ~p; a_key = ~k; a_mode = ~m;
      while (!a_out_vld && lat < 100) begin
         @(negedge clk_i);
         lat++;
      end
      res = a_dat_o;
      cnt = a_cnt;
      a_out_rdy = 1'b1;
      @(negedge clk_i);
      a_out_rdy = 1'b0;
   endtask

   task automatic run_b(input logic [127:0] p, input logic [127:0] k, input logic m,
                        output logic [127:0] res, output int lat, output logic [7:0] cnt);
      @(negedge clk_i);
      b_in_vld = 1'b1; b_dat = p; b_key = k; b_mode = m;
      @(negedge clk_i);
      lat = 1;
      b_in_vld = 1'b0; b_dat = ~p; b_key = ~k; b_mode = ~m;
      while (!b_out_vld && lat < 100) begin
         @(negedge clk_i);
         lat++;
      end
      res = b_dat_o;
      cnt = b_cnt;
      b_out_rdy = 1'b1;
      @(negedge clk_i);
      b_out_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      a_in_vld = 1'b0; a_dat = '0; a_key = '0; a_mode = 1'b0; a_out_rdy = 1'b0;
      b_in_vld = 1'b0; b_dat = '0; b_key = '0; b_mode = 1'b0; b_out_rdy = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if ({a_in_rdy, a_out_vld, a_busy} !== 3'b100) $display("FAIL reset_a_flags got=%b exp=100", {a_in_rdy, a_out_vld, a_busy});
      else n_pass++;
      n_checks++;
      if ({a_cnt, a_dat_o} !== 24'h0) $display("FAIL reset_a_cnt_data got=%h exp=000000", {a_cnt, a_dat_o});
      else n_pass++;
      n_checks++;
      if ({b_in_rdy, b_out_vld, b_busy} !== 3'b100) $display("FAIL reset_b_flags got=%b exp=100", {b_in_rdy, b_out_vld, b_busy});
      else n_pass++;
      n_checks++;
      if (b_cnt !== 8'd0 || b_dat_o !== 128'd0) $display("FAIL reset_b_cnt_data got cnt=%0d data=%h exp 0/0", b_cnt, b_dat_o);
      else n_pass++;
   endtask

   task automatic test_small_vectors();
      logic [15:0] res;
      int          lat;
      logic [7:0]  cnt;
      run_a(16'h1234, 16'h00FF, 1'b0, res, lat, cnt);
      n_checks++;
      if (res !== 16'h4634) $display("FAIL small_enc got=%h exp=4634", res);
      else n_pass++;
      n_checks++;
      if (lat !== 2) $display("FAIL small_enc_latency got=%0d exp=2", lat);
      else n_pass++;
      n_checks++;
      if (cnt !== 8'd1) $display("FAIL small_enc_round_cnt got=%0d exp=1", cnt);
      else n_pass++;
      run_a(16'h4634, 16'h00FF, 1'b1, res, lat, cnt);
      n_checks++;
      if (res !== 16'h1234) $display("FAIL small_dec got=%h exp=1234", res);
      else n_pass++;
      run_a(16'h0000, 16'h0000, 1'b1, res, lat, cnt);
      n_checks++;
      if (res !== 16'h0000) $display("FAIL small_dec_zero got=%h exp=0000", res);
      else n_pass++;
      run_a(16'h0000, 16'h0000, 1'b0, res, lat, cnt);
      n_checks++;
      if (res !== 16'h0000) $display("FAIL small_enc_zero got=%h exp=0000", res);
      else n_pass++;
   endtask

   task automatic test_roundtrip();
      logic [127:0] p, k, c, d;
      int           lat;
      logic [7:0]   cnt;
      for (int i = 0; i < 200; i++) begin
         p = {$urandom(), $urandom(), $urandom(), $urandom()};
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_b(p, k, 1'b0, c, lat, cnt);
         n_checks++;
         if (c !== model_enc(p, k)) $display("FAIL rt_enc[%0d] got=%h exp=%h", i, c, model_enc(p, k));
         else n_pass++;
         n_checks++;
         if (lat !== 17 || cnt !== 8'd16) $display("FAIL rt_enc_timing[%0d] got lat=%0d cnt=%0d exp 17/16", i, lat, cnt);
         else n_pass++;
         run_b(c, k, 1'b1, d, lat, cnt);
         n_checks++;
         if (d !== p) $display("FAIL rt_dec[%0d] got=%h exp=%h", i, d, p);
         else n_pass++;
         n_checks++;
         if (lat !== 17 || cnt !== 8'd16) $display("FAIL rt_dec_timing[%0d] got lat=%0d cnt=%0d exp 17/16", i, lat, cnt);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] p, k, exp;
      int           n;
      p   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      k   = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      exp = model_enc(p, k);
      @(negedge clk_i);
      b_in_vld = 1'b1; b_dat = p; b_key = k; b_mode = 1'b0;
      @(negedge clk_i);
      b_in_vld = 1'b0;
      n = 1;
      while (!b_out_vld && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      n_checks++;
      if (n !== 17) $display("FAIL bp_latency got=%0d exp=17", n);
      else n_pass++;
      // A competing block is offered throughout the stall and must be dropped
      b_in_vld = 1'b1; b_dat = ~p; b_key = ~k;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         n_checks++;
         if (b_out_vld !== 1'b1 || b_in_rdy !== 1'b0 || b_dat_o !== exp)
            $display("FAIL bp_hold[%0d] got vld=%b rdy=%b data=%h exp 1/0/%h", i, b_out_vld, b_in_rdy, b_dat_o, exp);
         else n_pass++;
      end
      b_in_vld = 1'b0;
      b_out_rdy = 1'b1;
      @(negedge clk_i);
      b_out_rdy = 1'b0;
      n_checks++;
      if (b_out_vld !== 1'b0 || b_in_rdy !== 1'b1) $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", b_out_vld, b_in_rdy);
      else n_pass++;
      @(negedge clk_i);
      n_checks++;
      if (b_busy !== 1'b0 || b_in_rdy !== 1'b1) $display("FAIL bp_no_accept got busy=%b rdy=%b exp 0/1", b_busy, b_in_rdy);
      else n_pass++;
   endtask

   task automatic test_busy_ignore();
      logic [127:0] p1, k1, exp;
      int           n;
      p1  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      k1  = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
      exp = model_enc(p1, k1);
      @(negedge clk_i);
      b_in_vld = 1'b1; b_dat = p1; b_key = k1; b_mode = 1'b0;
      @(negedge clk_i);
      n = 1;
      b_dat = ~p1; b_key = k1 ^ 128'h1; b_mode = 1'b1;
      n_checks++;
      if (b_busy !== 1'b1 || b_in_rdy !== 1'b0) $display("FAIL busy_flags got busy=%b rdy=%b exp 1/0", b_busy, b_in_rdy);
      else n_pass++;
      repeat (4) begin
         @(negedge clk_i);
         n++;
      end
      b_in_vld = 1'b0;
      n_checks++;
      if (b_cnt !== 8'd4) $display("FAIL busy_round_cnt got=%0d exp=4", b_cnt);
      else n_pass++;
      while (!b_out_vld && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      n_checks++;
      if (n !== 17 || b_dat_o !== exp) $display("FAIL busy_result got lat=%0d data=%h exp 17/%h", n, b_dat_o, exp);
      else n_pass++;
      b_out_rdy = 1'b1;
      @(negedge clk_i);
      b_out_rdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [127:0] p, k, res;
      int           n, lat;
      logic [7:0]   cnt;
      p = 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF;
      k = 128'h80000000_00000000_00000000_00000001;
      @(negedge clk_i);
      b_in_vld = 1'b1; b_dat = p; b_key = k; b_mode = 1'b0;
      @(negedge clk_i);
      b_in_vld = 1'b0;
      n = 0;
      while (b_cnt !== 8'd5 && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      n_checks++;
      if (b_cnt !== 8'd5) $display("FAIL rst_mid_reach got cnt=%0d exp=5", b_cnt);
      else n_pass++;
      rst_ni = 1'b0;
      #1;
      n_checks++;
      if ({b_out_vld, b_in_rdy, b_busy} !== 3'b010 || b_cnt !== 8'd0 || b_dat_o !== 128'd0)
         $display("FAIL rst_mid_clear got vld/rdy/busy=%b cnt=%0d data=%h exp 010/0/0", {b_out_vld, b_in_rdy, b_busy}, b_cnt, b_dat_o);
      else n_pass++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_b(k, p, 1'b0, res, lat, cnt);
      n_checks++;
      if (res !== model_enc(k, p) || lat !== 17) $display("FAIL rst_mid_fresh got=%h lat=%0d exp=%h/17", res, lat, model_enc(k, p));
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_small_vectors();
      test_roundtrip();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
